// File: rtl/clmul16_kara_seq.sv
// clmul16_kara_seq: sequenced 2*HALF_W x 2*HALF_W carry-less multiplier.
// A single HALF_W x HALF_W carry-less slice is shared across the three
// Karatsuba sub-products (lo, hi, mid). The result is folded into rp
// on the MUL_MID edge and presented in DONE with a valid/ready handshake.
module clmul16_kara_seq #(
    parameter int unsigned HALF_W = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2*HALF_W-1:0]   in_a,
    input  logic [2*HALF_W-1:0]   in_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*HALF_W-1:0]   out_p,
    output logic                  busy
);

    localparam int unsigned OW = 2 * HALF_W;      // operand width
    localparam int unsigned PW = 2 * HALF_W - 1;  // slice product width
    localparam int unsigned FW = 4 * HALF_W;      // full product width

    typedef enum logic [2:0] {
        IDLE,
        MUL_LO,
        MUL_HI,
        MUL_MID,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [OW-1:0] ra_q, ra_d;
    logic [OW-1:0] rb_q, rb_d;
    logic [PW-1:0] rl_q, rl_d;
    logic [PW-1:0] rh_q, rh_d;
    logic [PW-1:0] rm_q, rm_d;
    logic [FW-1:0] rp_q, rp_d;

    logic [HALF_W-1:0] a_lo, a_hi, b_lo, b_hi;
    logic [HALF_W-1:0] slice_a, slice_b;
    logic [PW-1:0]     slice_a_ext;
    logic [PW-1:0]     slice_p;

    logic [PW-1:0]     mid_term;
    logic [PW-1:0]     mid_fold;
    logic [FW-1:0]     lo_ext, hi_ext, mid_ext;

    assign a_lo = ra_q[HALF_W-1:0];
    assign a_hi = ra_q[OW-1:HALF_W];
    assign b_lo = rb_q[HALF_W-1:0];
    assign b_hi = rb_q[OW-1:HALF_W];

    assign out_p = rp_q;

    // Select the slice operands for the sub-product owned by the current state.
    always_comb begin
        slice_a = '0;
        slice_b = '0;
        case (state_q)
            MUL_LO: begin
                slice_a = a_lo;
                slice_b = b_lo;
            end
            MUL_HI: begin
                slice_a = a_hi;
                slice_b = b_hi;
            end
            MUL_MID: begin
                slice_a = a_lo ^ a_hi;
                slice_b = b_lo ^ b_hi;
            end
            default: begin
                slice_a = '0;
                slice_b = '0;
            end
        endcase
    end

    // Shared HALF_W x HALF_W carry-less multiplier: AND/XOR shift-accumulate.
    always_comb begin
        slice_a_ext = {{(PW - HALF_W){1'b0}}, slice_a};
        slice_p     = '0;
        for (int unsigned i = 0; i < HALF_W; i++) begin
            if (slice_b[i]) begin
                slice_p = slice_p ^ (slice_a_ext << i);
            end
        end
    end

    // Karatsuba fold: hi<<OW ^ (m^hi^lo)<<HALF_W ^ lo, all terms zero-extended.
    always_comb begin
        // rp is only committed in MUL_MID, where the live slice output is the
        // middle product; elsewhere the stored rm stands in for it.
        mid_term = (state_q == MUL_MID) ? slice_p : rm_q;
        mid_fold = mid_term ^ rh_q ^ rl_q;
        lo_ext   = {{(FW - PW){1'b0}}, rl_q};
        hi_ext   = {{(FW - PW){1'b0}}, rh_q} << OW;
        mid_ext  = {{(FW - PW){1'b0}}, mid_fold} << HALF_W;
    end

    // Next-state, register updates and handshake outputs.
    always_comb begin
        state_d   = state_q;
        ra_d      = ra_q;
        rb_d      = rb_q;
        rl_d      = rl_q;
        rh_d      = rh_q;
        rm_d      = rm_q;
        rp_d      = rp_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    ra_d    = in_a;
                    rb_d    = in_b;
                    state_d = MUL_LO;
                end
            end
            MUL_LO: begin
                rl_d    = slice_p;
                state_d = MUL_HI;
            end
            MUL_HI: begin
                rh_d    = slice_p;
                state_d = MUL_MID;
            end
            MUL_MID: begin
                rm_d    = slice_p;
                rp_d    = hi_ext ^ mid_ext ^ lo_ext;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            rl_q    <= '0;
            rh_q    <= '0;
            rm_q    <= '0;
            rp_q    <= '0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rl_q    <= rl_d;
            rh_q    <= rh_d;
            rm_q    <= rm_d;
            rp_q    <= rp_d;
        end
    end

endmodule

// File: tb/tb_clmul16_kara_seq.sv
// Self-checking bench for clmul16_kara_seq: directed corner cases plus a
// randomized stream with output stalls, scored against a shift-and-XOR model.
module tb_clmul16_kara_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_p;
    logic        busy;

    int n_cmp;
    int n_err;

    clmul16_kara_seq #(.HALF_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Polynomial product over GF(2), straight from the definition.
    function automatic logic [31:0] clmul_ref(input logic [15:0] a, input logic [15:0] b);
        logic [31:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) begin
            if (b[i]) acc = acc ^ ({16'h0000, a} << i);
        end
        return acc;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one operand pair; returns the product and cycles from accept to out_valid.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b,
                          output logic [31:0] p, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        p = out_p;
    endtask

    task automatic basic(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp);
        logic [31:0] p;
        int          lat;
        out_ready = 1'b1;
        run_op(a, b, p, lat);
        check(tag, p, exp);
        check({tag, "_latency"}, 32'(lat), 32'd3);
        tick();
        check({tag, "_back_idle"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] held;
        int          lat;
        int          stable_bad;
        logic [31:0] exp_q[$];
        int          sent;
        int          got;
        int          cycles;
        logic [15:0] ra, rb;

        n_cmp     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        out_ready = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_p", out_p, 32'd0);
        rst = 1'b0;
        tick();

        // Directed products
        basic("basic_1234", 16'h1234, 16'h0001, 32'h0000_1234);
        basic("square_ffff", 16'hFFFF, 16'hFFFF, 32'h5555_5555);
        basic("square_0003", 16'h0003, 16'h0003, 32'h0000_0005);
        basic("square_8000", 16'h8000, 16'h8000, 32'h4000_0000);
        check("msb_zero_8000", 32'(out_p[31]), 32'd0);
        basic("square_0100", 16'h0100, 16'h0100, 32'h0001_0000);
        basic("mixed_abcd", 16'hABCD, 16'h1357, clmul_ref(16'hABCD, 16'h1357));

        // Back-pressure: DONE held, out_p stable, in_ready low
        out_ready = 1'b0;
        run_op(16'hBEEF, 16'hCAFE, p, lat);
        check("bp_result", p, clmul_ref(16'hBEEF, 16'hCAFE));
        held       = out_p;
        stable_bad = 0;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_a     = 16'h0F0F;
            in_b     = 16'h00FF;
            tick();
            if (out_p !== held || in_ready !== 1'b0 || out_valid !== 1'b1) stable_bad++;
        end
        in_valid = 1'b0;
        check("bp_stable_cycles_bad", 32'(stable_bad), 32'd0);
        check("bp_out_p_held", out_p, clmul_ref(16'hBEEF, 16'hCAFE));
        out_ready = 1'b1;
        tick();
        check("bp_release_idle", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd0);

        // Ignored in_valid pulse during MUL_HI
        in_a     = 16'h1234;
        in_b     = 16'h0001;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        in_valid = 1'b1;
        check("ign_in_ready_low", 32'(in_ready), 32'd0);
        tick();
        in_valid = 1'b0;
        tick();
        check("ign_out_valid", 32'(out_valid), 32'd1);
        check("ign_result", out_p, 32'h0000_1234);
        tick();
        check("ign_back_idle", 32'(in_ready), 32'd1);
        tick();
        check("ign_no_second_result", 32'(out_valid), 32'd0);

        // Asynchronous reset while in MUL_MID
        in_a     = 16'hFFFF;
        in_b     = 16'hFFFF;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        check("mid_busy_before_rst", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_in_ready", 32'(in_ready), 32'd1);
        check("mrst_out_p", out_p, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_no_stale", 32'(out_valid), 32'd0);
        basic("post_rst_0003", 16'h0003, 16'h0003, 32'h0000_0005);

        // Random stream with output stalls, in-order scoreboard
        sent   = 0;
        got    = 0;
        cycles = 0;
        in_valid = 1'b0;
        while (got < 2000 && cycles < 40000) begin
            if (!in_valid && sent < 2000 && $urandom_range(0, 3) != 0) begin
                ra       = 16'($urandom);
                rb       = 16'($urandom);
                in_a     = ra;
                in_b     = rb;
                in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("rand_unexpected_result", out_p, 32'hXXXX_XXXX);
                end else begin
                    check("rand_product", out_p, exp_q.pop_front());
                end
                got++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(clmul_ref(in_a, in_b));
                sent++;
            end
            check("rand_busy_vs_ready", 32'(busy), 32'(!in_ready));
            tick();
            if (in_valid && !busy) begin
                // accepted on the previous edge only if the block moved out of IDLE
            end
            if (in_valid && busy && exp_q.size() > 0 && sent > got) begin
                in_valid = 1'b0;
            end
            cycles++;
        end
        in_valid = 1'b0;
        check("rand_all_received", 32'(got), 32'd2000);
        check("rand_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
